stream_demux: RTL
=================

# stream_demux

Parametrised, registered demultiplexer with valid/ready handshakes. Routes one DATA_WIDTH payload per cycle from a single input stream to one of NUM_OUTPUTS output channels selected by i_select. Each channel has a one-entry buffer, so a stalled channel does not block traffic to the others. Out-of-range selects are accepted, dropped and counted. It is the handshaked successor of the combinational one-hot demux and sits between the issue logic and per-unit consumers.

## Interface
- NUM_OUTPUTS, 5, number of output channels, ≥2.
- DATA_WIDTH, 32, payload width in bits.
- SEL_W, $clog2(NUM_OUTPUTS), select width; derived and never overridden.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_enable  in  1  global accept enable; drain is unaffected.
- i_flush  in  1  synchronous clear of all channel buffers.
- i_valid  in  1  input payload valid.
- o_ready  out  1  input accepted this cycle when i_valid && o_ready; combinational.
- i_select  in  SEL_W  target channel index.
- i_data  in  DATA_WIDTH  input payload.
- o_valid  out  NUM_OUTPUTS  per-channel valid, bit k = channel k buffer full.
- i_ready  in  NUM_OUTPUTS  per-channel consumer ready.
- o_data  out  NUM_OUTPUTS×DATA_WIDTH  packed [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0], per-channel payload.
- o_err  out  1  one-cycle pulse after an out-of-range select is accepted.
- o_drop_count  out  DROP_CNT_W  saturating count of dropped payloads.

## Operation
- Each channel k holds full[k] and data[k]. o_valid[k] = full[k]. o_data[k] = data[k].
- sel_ok = (i_select < NUM_OUTPUTS).
- o_ready = i_enable && !i_flush && (!sel_ok || !full[i_select] || i_ready[i_select]).
- o_ready depends combinationally on i_select and i_ready. i_valid must not depend on o_ready.
- Accept with sel_ok:
  - data[i_select] ← i_data.
  - full[i_select] ← 1.
  - If channel i_select drains in the same cycle, it refills without a bubble.
- Accept with !sel_ok:
  - Payload is discarded and no buffer changes.
  - o_err ← 1 for the next cycle.
  - o_drop_count increments, saturating at all-ones.
- Drain: when full[k] && i_ready[k], full[k] ← 0 unless refilled the same cycle. Channels drain independently and simultaneously.
- i_enable low: o_ready = 0. Buffered entries still drain.
- i_flush: full[*] ← 0 and o_ready = 0. Flush overrides both accept and drain. data registers, o_err and o_drop_count are untouched.
- Holding rule: o_data[k] is stable while o_valid[k] && !i_ready[k].

## Timing
- Reset values: full = 0, o_valid = 0, o_data = 0, o_err = 0, o_drop_count = 0. o_ready follows its equation and is 0 while i_rst is high.
- Reset mid-operation discards buffered entries. Reset has priority over flush, accept and drain.
- Latency: accept in cycle n, so o_valid[sel] = 1 in cycle n+1.
- o_err is high in cycle n+1 only.
- Throughput: 1 payload/cycle into any channel whose consumer holds i_ready high.
- A channel whose consumer has i_ready low accepts at most one entry, then back-pressures only selects targeting it.
- o_drop_count wraps never; at 16'hFFFF it holds.

## Structure
- Package demux_pkg: localparam DROP_CNT_W = 16. Shared with the other demux/arbiter blocks.
- Sub-module stream_slot (DATA_WIDTH): one-entry buffer with in valid/ready and out valid/ready, refill-on-drain. Instantiated NUM_OUTPUTS times via generate.
- Top level contains select decode, ready mux, drop logic and counter.

## Test plan
- Reset, then i_valid=1, i_select=2, i_data=32'hA5A5_0002, all i_ready=1 → cycle+1: o_valid=5'b00100, o_data[2]=32'hA5A5_0002. Next cycle o_valid=0.
- Channel 1 i_ready=0, send two payloads to channel 1 → first accepted, second sees o_ready=0. A payload to channel 3 in the same cycle as the stall is accepted. Raise i_ready[1] → second payload accepted, no bubble.
- i_select=7 (out of range), i_valid=1 → o_ready=1, all o_valid stay 0, o_err pulses one cycle, o_drop_count=1. Force count to 16'hFFFF, drop again → it stays 16'hFFFF.
- i_enable=0 with channel 0 full, i_ready[0]=1 → o_ready=0, channel 0 drains, nothing new accepted.
- Channels 0 and 4 full, assert i_flush with i_valid=1 → next cycle o_valid=0, input not accepted.
- Assert i_rst while 3 channels are full with a drop pending → next cycle all outputs are at their reset values.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: constants and types shared by the demux/arbiter blocks
package demux_pkg;
    localparam int DROP_CNT_W = 16;
    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;
endpackage

// File: rtl/stream_slot.sv
// stream_slot: one-entry valid/ready buffer that refills on the cycle it drains
module stream_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);
    logic                  full_q, full_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  load;

    assign in_ready_o  = !full_q || out_ready_i;
    assign load        = in_valid_i && in_ready_o && !flush_i;
    assign out_valid_o = full_q;
    assign out_data_o  = data_q;

    // flush wins over load and drain; a load in the draining cycle keeps the slot full
    always_comb begin
        full_d = flush_i ? 1'b0 : load ? 1'b1 : (full_q && out_ready_i) ? 1'b0 : full_q;
        data_d = load ? in_data_i : data_q;
    end

    // slot state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/stream_demux.sv
// stream_demux: routes one input stream to per-channel one-entry buffers, dropping bad selects
module stream_demux
    import demux_pkg::*;
#(
    parameter int NUM_OUTPUTS = 5,
    parameter int DATA_WIDTH  = 32,
    localparam int SEL_W      = $clog2(NUM_OUTPUTS)
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_enable,
    input  logic                                  i_flush,
    input  logic                                  i_valid,
    output logic                                  o_ready,
    input  logic [SEL_W-1:0]                      i_select,
    input  logic [DATA_WIDTH-1:0]                 i_data,
    output logic [NUM_OUTPUTS-1:0]                o_valid,
    input  logic [NUM_OUTPUTS-1:0]                i_ready,
    output logic [NUM_OUTPUTS-1:0][DATA_WIDTH-1:0] o_data,
    output logic                                  o_err,
    output logic [DROP_CNT_W-1:0]                 o_drop_count
);
    logic [NUM_OUTPUTS-1:0] slot_ready;
    logic                   sel_ok, sel_ready, accept;
    logic                   err_q, err_d;
    drop_cnt_t              cnt_q, cnt_d;

    assign sel_ok       = {1'b0, i_select} < (SEL_W + 1)'(NUM_OUTPUTS);
    assign sel_ready    = sel_ok ? slot_ready[i_select] : 1'b1;
    assign o_ready      = !i_rst && i_enable && !i_flush && sel_ready;
    assign accept       = i_valid && o_ready;
    assign o_err        = err_q;
    assign o_drop_count = cnt_q;

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_slot
        stream_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
            .clk_i      (i_clk),
            .rst_i      (i_rst),
            .flush_i    (i_flush),
            .in_valid_i (accept && sel_ok && (i_select == SEL_W'(k))),
            .in_ready_o (slot_ready[k]),
            .in_data_i  (i_data),
            .out_valid_o(o_valid[k]),
            .out_ready_i(i_ready[k]),
            .out_data_o (o_data[k])
        );
    end

    // an accepted out-of-range select pulses err and bumps the saturating counter
    always_comb begin
        err_d = accept && !sel_ok;
        cnt_d = (err_d && cnt_q != '1) ? cnt_q + DROP_CNT_W'(1) : cnt_q;
    end

    // drop tracking registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
endmodule
